// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rst_sequencer
// Purpose  : Reset generator between the board clock/reset pins and the SoC.
//            Synchronises the push-button release and the PLL lock flag.
//            It qualifies lock for LOCK_STABLE cycles, then releases NUM_CH
//            active-low resets one at a time, STAGGER cycles apart, in
//            ascending order. PLL lock loss or a software request puts every
//            channel back into reset, and the cause is recorded.
// Ports    : clk_50M      - block clock
//            reset_btn    - board reset, asynchronous, active-low
//            pll_locked   - PLL lock, asynchronous to clk_50M
//            sw_rst_req   - single-cycle software reset request (clk_50M)
//            rst_n_out    - per-channel active-low resets, channel 0 first
//            all_released - high once every channel is released
//            rst_cause    - 01 button, 10 PLL loss, 11 software
// Revision : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STABLE = 8,
  parameter int STAGGER     = 4
) (
  input  logic              clk_50M,
  input  logic              reset_btn,
  input  logic              pll_locked,
  input  logic              sw_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              all_released,
  output logic [1:0]        rst_cause
);

  localparam int LOCK_W   = $clog2(LOCK_STABLE + 1);
  localparam int STAG_MAX = STAGGER * (NUM_CH - 1);
  localparam int STAG_W   = (STAG_MAX > 0) ? $clog2(STAG_MAX + 1) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAG_MAX);

  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_PLL = 2'b10;
  localparam logic [1:0] CAUSE_SW  = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  state_t                 state_q, state_d;
  logic [LOCK_W-1:0]      lock_cnt_q, lock_cnt_d;
  logic [STAG_W-1:0]      stag_cnt_q, stag_cnt_d;
  logic [NUM_CH-1:0]      rst_n_q, rst_n_d;
  logic                   all_rel_q, all_rel_d;
  logic [1:0]             cause_q, cause_d;

  logic                   btn_ok;
  logic                   locked_s;
  logic                   qualified;
  logic [STAG_W-1:0]      stag_next;
  logic [NUM_CH-1:0]      ch_due;

  assign btn_ok    = btn_sync_q[SYNC_STAGES-1];
  assign locked_s  = lock_sync_q[SYNC_STAGES-1];
  assign qualified = btn_ok & locked_s;
  assign stag_next = stag_cnt_q + STAG_W'(1);

  // Channel k becomes due once k*STAGGER edges have passed since channel 0
  // was released; OR-ing into the held vector keeps the order monotonic.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch_due
    assign ch_due[k] = (int'(stag_next) >= k * STAGGER);
  end

  always_comb begin
    btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], 1'b1};
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    stag_cnt_d  = stag_cnt_q;
    rst_n_d     = rst_n_q;
    all_rel_d   = all_rel_q;
    cause_d     = cause_q;

    case (state_q)
      ST_WAIT: begin
        rst_n_d   = '0;
        all_rel_d = 1'b0;
        if (qualified) begin
          if (lock_cnt_q == LOCK_LAST) begin
            lock_cnt_d = '0;
            stag_cnt_d = '0;
            rst_n_d    = NUM_CH'(1);
            if (NUM_CH == 1) begin
              all_rel_d = 1'b1;
              state_d   = ST_RUN;
            end else begin
              state_d   = ST_RELEASE;
            end
          end else begin
            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
          end
        end else begin
          // Any gap in lock (or button) restarts qualification from zero.
          lock_cnt_d = '0;
        end
      end

      ST_RELEASE, ST_RUN: begin
        if (!locked_s || sw_rst_req) begin
          // PLL loss outranks a simultaneous software request.
          rst_n_d    = '0;
          all_rel_d  = 1'b0;
          cause_d    = locked_s ? CAUSE_SW : CAUSE_PLL;
          lock_cnt_d = '0;
          stag_cnt_d = '0;
          state_d    = ST_WAIT;
        end else if (state_q == ST_RELEASE) begin
          stag_cnt_d = stag_next;
          rst_n_d    = rst_n_q | ch_due;
          if (stag_next == STAG_LAST) begin
            all_rel_d  = 1'b1;
            stag_cnt_d = '0;
            state_d    = ST_RUN;
          end
        end
      end

      default: begin
        rst_n_d    = '0;
        all_rel_d  = 1'b0;
        lock_cnt_d = '0;
        stag_cnt_d = '0;
        state_d    = ST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset_btn) begin
    if (!reset_btn) begin
      btn_sync_q  <= '0;
      lock_sync_q <= '0;
      state_q     <= ST_WAIT;
      lock_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      rst_n_q     <= '0;
      all_rel_q   <= 1'b0;
      cause_q     <= CAUSE_BTN;
    end else begin
      btn_sync_q  <= btn_sync_d;
      lock_sync_q <= lock_sync_d;
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      stag_cnt_q  <= stag_cnt_d;
      rst_n_q     <= rst_n_d;
      all_rel_q   <= all_rel_d;
      cause_q     <= cause_d;
    end
  end

  assign rst_n_out    = rst_n_q;
  assign all_released = all_rel_q;
  assign rst_cause    = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_sequencer
// Purpose  : Self-checking bench for rst_sequencer. A reference model tracks
//            the edge at which channel 0 was released and derives each
//            channel's state from elapsed edges. Directed scenarios are
//            followed by a randomised phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

  localparam int NUM_CH      = 3;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_STABLE = 8;
  localparam int STAGGER     = 4;

  logic              clk_50M    = 1'b0;
  logic              reset_btn  = 1'b0;
  logic              pll_locked = 1'b1;
  logic              sw_rst_req = 1'b0;
  logic [NUM_CH-1:0] rst_n_out;
  logic              all_released;
  logic [1:0]        rst_cause;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk_50M = ~clk_50M;

  rst_sequencer #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .LOCK_STABLE (LOCK_STABLE),
    .STAGGER     (STAGGER)
  ) dut (
    .clk_50M      (clk_50M),
    .reset_btn    (reset_btn),
    .pll_locked   (pll_locked),
    .sw_rst_req   (sw_rst_req),
    .rst_n_out    (rst_n_out),
    .all_released (all_released),
    .rst_cause    (rst_cause)
  );

  // ---------------- reference model ----------------
  bit         m_lock_hist[SYNC_STAGES];  // pll_locked samples, newest first
  bit         m_btn_hist[SYNC_STAGES];
  int         m_edge;                    // edges since reset_btn release
  int         m_rel_edge;                // edge that released channel 0
  int         m_qual;                    // consecutive qualifying edges
  bit         m_active;                  // channel 0 released, sequence live
  logic [1:0] m_cause;

  task automatic model_reset();
    for (int i = 0; i < SYNC_STAGES; i++) begin
      m_lock_hist[i] = 1'b0;
      m_btn_hist[i]  = 1'b0;
    end
    m_edge     = 0;
    m_rel_edge = 0;
    m_qual     = 0;
    m_active   = 1'b0;
    m_cause    = 2'b01;
  endtask

  task automatic model_edge(input logic pll, input logic sw);
    bit ls, bo;
    ls = m_lock_hist[SYNC_STAGES-1];
    bo = m_btn_hist[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
      m_lock_hist[i] = m_lock_hist[i-1];
      m_btn_hist[i]  = m_btn_hist[i-1];
    end
    m_lock_hist[0] = pll;
    m_btn_hist[0]  = 1'b1;
    m_edge++;
    if (m_active) begin
      if (!ls) begin
        m_cause  = 2'b10;
        m_active = 1'b0;
        m_qual   = 0;
      end else if (sw) begin
        m_cause  = 2'b11;
        m_active = 1'b0;
        m_qual   = 0;
      end
    end else if (bo && ls) begin
      m_qual++;
      if (m_qual == LOCK_STABLE) begin
        m_active   = 1'b1;
        m_rel_edge = m_edge;
        m_qual     = 0;
      end
    end else begin
      m_qual = 0;
    end
  endtask

  function automatic logic [NUM_CH-1:0] exp_rst();
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (m_active && (m_edge - m_rel_edge) >= k * STAGGER) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_all();
    return m_active && ((m_edge - m_rel_edge) >= (NUM_CH - 1) * STAGGER);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/rst_n"}, 32'(rst_n_out), 32'(exp_rst()));
    check({tag, "/all"},   32'(all_released), 32'(exp_all()));
    check({tag, "/cause"}, 32'(rst_cause), 32'(m_cause));
  endtask

  // Called at a negedge: drive inputs, advance one edge, check at the next negedge.
  task automatic cycle(input logic pll, input logic sw, input string tag);
    pll_locked = pll;
    sw_rst_req = sw;
    @(posedge clk_50M);
    model_edge(pll, sw);
    @(negedge clk_50M);
    check_model(tag);
  endtask

  // Pull reset_btn low between edges; return at a negedge with it released,
  // so the next posedge is E0.
  task automatic async_reset(input string tag);
    #5 reset_btn = 1'b0;
    model_reset();
    #1;
    check({tag, "/async_rst_n"}, 32'(rst_n_out), 32'h0);
    check({tag, "/async_cause"}, 32'(rst_cause), 32'h1);
    check({tag, "/async_all"},   32'(all_released), 32'h0);
    @(negedge clk_50M);
    @(negedge clk_50M);
    check({tag, "/held_rst_n"}, 32'(rst_n_out), 32'h0);
    reset_btn = 1'b1;
  endtask

  // Power-up with lock present: edge Ei is loop index i.
  task automatic powerup_seq(input string tag);
    for (int e = 0; e <= 18; e++) begin
      cycle(1'b1, 1'b0, tag);
      if (e == 8)  check({tag, "/e8"},  32'(rst_n_out), 32'b000);
      if (e == 9)  check({tag, "/e9"},  32'(rst_n_out), 32'b001);
      if (e == 12) check({tag, "/e12"}, 32'(rst_n_out), 32'b001);
      if (e == 13) check({tag, "/e13"}, 32'(rst_n_out), 32'b011);
      if (e == 16) check({tag, "/e16"}, 32'(rst_n_out), 32'b011);
      if (e == 16) check({tag, "/e16_all"}, 32'(all_released), 32'h0);
      if (e == 17) check({tag, "/e17"}, 32'(rst_n_out), 32'b111);
      if (e == 17) check({tag, "/e17_all"}, 32'(all_released), 32'h1);
      check({tag, "/cause01"}, 32'(rst_cause), 32'h1);
    end
  endtask

  task automatic wait_all_released(input string tag);
    int n;
    n = 0;
    while (!exp_all() && n < 60) begin
      cycle(1'b1, 1'b0, tag);
      n++;
    end
    check({tag, "/reach_run"}, 32'(exp_all()), 32'h1);
  endtask

  initial begin
    bit pll_state;
    int n;
    model_reset();

    // Values while reset_btn is low
    repeat (3) @(negedge clk_50M);
    check("rst/rst_n", 32'(rst_n_out), 32'h0);
    check("rst/all",   32'(all_released), 32'h0);
    check("rst/cause", 32'(rst_cause), 32'h1);
    reset_btn = 1'b1;

    // Power-up
    powerup_seq("pwr");
    repeat (4) cycle(1'b1, 1'b0, "run");

    // Lock glitch during WAIT at E5
    async_reset("glitch");
    for (int e = 0; e <= 24; e++) begin
      cycle(e != 5, 1'b0, "glitch");
      if (e == 9)  check("glitch/e9",  32'(rst_n_out), 32'b000);
      if (e == 14) check("glitch/e14", 32'(rst_n_out), 32'b000);
      if (e == 15) check("glitch/e15", 32'(rst_n_out), 32'b001);
      if (e == 19) check("glitch/e19", 32'(rst_n_out), 32'b011);
      if (e == 23) check("glitch/e23", 32'(rst_n_out), 32'b111);
    end

    // PLL loss in RUN
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b0, "pll_loss");
    check("pll_loss/rst_n", 32'(rst_n_out), 32'h0);
    check("pll_loss/all",   32'(all_released), 32'h0);
    check("pll_loss/cause", 32'(rst_cause), 32'h2);
    wait_all_released("pll_restore");

    // Software reset mid-RELEASE
    async_reset("swrel");
    n = 0;
    while (exp_rst() != 3'b011 && n < 40) begin
      cycle(1'b1, 1'b0, "swrel_wait");
      n++;
    end
    check("swrel/reach_011", 32'(rst_n_out), 32'b011);
    cycle(1'b1, 1'b1, "swrel_pulse");
    check("swrel/rst_n", 32'(rst_n_out), 32'h0);
    check("swrel/cause", 32'(rst_cause), 32'h3);
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 1'b0, "swrel_re");
      if (i == 7)  check("swrel/i7",  32'(rst_n_out), 32'b000);
      if (i == 8)  check("swrel/i8",  32'(rst_n_out), 32'b001);
      if (i == 12) check("swrel/i12", 32'(rst_n_out), 32'b011);
    end
    wait_all_released("swrel_run");

    // Simultaneous PLL loss and software request: locked_s first reads 0
    // on the third edge after pll_locked drops.
    cycle(1'b0, 1'b0, "simul");
    cycle(1'b0, 1'b0, "simul");
    cycle(1'b0, 1'b1, "simul");
    check("simul/cause", 32'(rst_cause), 32'h2);
    check("simul/rst_n", 32'(rst_n_out), 32'h0);

    // Software request in WAIT is ignored
    cycle(1'b0, 1'b1, "sw_wait");
    cycle(1'b1, 1'b0, "sw_wait");
    cycle(1'b1, 1'b1, "sw_wait");
    check("sw_wait/cause", 32'(rst_cause), 32'h2);
    check("sw_wait/rst_n", 32'(rst_n_out), 32'h0);
    wait_all_released("sw_wait_run");

    // Async reset mid-RUN, then exact power-up timing again
    async_reset("async");
    powerup_seq("async_pwr");

    // Randomised phase
    pll_state = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (pll_state) begin
        if ($urandom_range(0, 99) < 2) pll_state = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 40) pll_state = 1'b1;
      end
      if ($urandom_range(0, 999) < 4) begin
        async_reset("rnd");
      end else begin
        cycle(pll_state, ($urandom_range(0, 99) < 2), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
